// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive frame controller: start/data/parity/stop, LSB-first deserializer
// Define UART_RX_BREAK_DET_EN to add the brk_det output and line-break handling.
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  sampled_bit,
    output logic                  dat_samp_en,
    output logic [3:0]            edge_cnt,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
`ifdef UART_RX_BREAK_DET_EN
    ,
    output logic                  brk_det
`endif
);

    localparam logic [3:0] EDGE_LAST = 4'(PRESCALE - 1);
    localparam logic [3:0] EDGE_CAPT = 4'd9;
    localparam logic [2:0] BIT_LAST  = 3'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
`ifdef UART_RX_BREAK_DET_EN
        ,
        BREAK
`endif
    } state_t;

    state_t                state, state_nx;
    logic [3:0]            edge_nx;
    logic [2:0]            bit_cnt, bit_nx;
    logic [DATA_WIDTH-1:0] shift, shift_nx, pdata_nx;
    logic                  par_en_q, par_en_nx, par_typ_q, par_typ_nx;
    logic                  perr_q, perr_nx;
    logic                  dv_nx, pe_nx, se_nx;
    logic                  wrap, capture, serr;
`ifdef UART_RX_BREAK_DET_EN
    logic                  par_bit_q, par_bit_nx, brk_nx;
`endif

    always_comb begin
        state_nx   = state;
        edge_nx    = edge_cnt;
        bit_nx     = bit_cnt;
        shift_nx   = shift;
        par_en_nx  = par_en_q;
        par_typ_nx = par_typ_q;
        perr_nx    = perr_q;
        pdata_nx   = P_DATA;
        dv_nx      = 1'b0;
        pe_nx      = 1'b0;
        se_nx      = 1'b0;
        serr       = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        par_bit_nx = par_bit_q;
        brk_nx     = 1'b0;
`endif
        wrap       = (edge_cnt == EDGE_LAST);
        capture    = (edge_cnt == EDGE_CAPT);

        if (state != IDLE) begin
            edge_nx = wrap ? 4'd0 : edge_cnt + 4'd1;
        end

        case (state)
            IDLE: begin
                edge_nx = 4'd0;
                if (!RX_IN) begin
                    state_nx   = START;
                    par_en_nx  = PAR_EN;
                    par_typ_nx = PAR_TYP;
                    perr_nx    = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
                    par_bit_nx = 1'b0;
`endif
                end
            end
            START: begin
                if (capture && sampled_bit) begin
                    state_nx = IDLE;
                    edge_nx  = 4'd0;
                end else if (wrap) begin
                    state_nx = DATA;
                    bit_nx   = 3'd0;
                end
            end
            DATA: begin
                if (capture) begin
                    shift_nx = {sampled_bit, shift[DATA_WIDTH-1:1]};
                end
                if (wrap) begin
                    if (bit_cnt == BIT_LAST) begin
                        state_nx = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_nx = bit_cnt + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (capture) begin
                    perr_nx = (^shift) ^ par_typ_q ^ sampled_bit;
`ifdef UART_RX_BREAK_DET_EN
                    par_bit_nx = sampled_bit;
`endif
                end
                if (wrap) begin
                    state_nx = STOP;
                end
            end
            STOP: begin
                // Leave at the stop-bit capture so a start edge right after it is not missed.
                if (capture) begin
                    state_nx = IDLE;
                    edge_nx  = 4'd0;
                    serr     = ~sampled_bit;
`ifdef UART_RX_BREAK_DET_EN
                    if ((shift == '0) && !par_bit_q && !sampled_bit) begin
                        state_nx = BREAK;
                        edge_nx  = edge_cnt + 4'd1;
                        brk_nx   = 1'b1;
                    end else
`endif
                    begin
                        dv_nx    = ~perr_q & ~serr;
                        pe_nx    = perr_q;
                        se_nx    = serr;
                        pdata_nx = (~perr_q & ~serr) ? shift : P_DATA;
                    end
                end
            end
`ifdef UART_RX_BREAK_DET_EN
            BREAK: begin
                if (capture && RX_IN) begin
                    state_nx = IDLE;
                    edge_nx  = 4'd0;
                end
            end
`endif
            default: begin
                state_nx = IDLE;
                edge_nx  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            edge_cnt    <= 4'd0;
            bit_cnt     <= 3'd0;
            shift       <= '0;
            par_en_q    <= 1'b0;
            par_typ_q   <= 1'b0;
            perr_q      <= 1'b0;
            dat_samp_en <= 1'b0;
            P_DATA      <= '0;
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            par_bit_q   <= 1'b0;
            brk_det     <= 1'b0;
`endif
        end else begin
            state       <= state_nx;
            edge_cnt    <= edge_nx;
            bit_cnt     <= bit_nx;
            shift       <= shift_nx;
            par_en_q    <= par_en_nx;
            par_typ_q   <= par_typ_nx;
            perr_q      <= perr_nx;
            dat_samp_en <= (state_nx != IDLE);
            P_DATA      <= pdata_nx;
            data_valid  <= dv_nx;
            par_err     <= pe_nx;
            stp_err     <= se_nx;
`ifdef UART_RX_BREAK_DET_EN
            par_bit_q   <= par_bit_nx;
            brk_det     <= brk_nx;
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - scoreboard bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

    localparam logic [3:0] K_DV  = 4'b0001;
    localparam logic [3:0] K_PE  = 4'b0010;
    localparam logic [3:0] K_SE  = 4'b0100;
    localparam logic [3:0] K_BRK = 4'b1000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic       sampled_bit;
    logic       dat_samp_en, data_valid, par_err, stp_err, brk;
    logic [3:0] edge_cnt;
    logic [7:0] p_data;

    typedef struct {
        logic [3:0] kind;
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] last_good = 8'h00;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Line is stable mid-bit, so the sampler's majority vote equals the line itself.
    assign sampled_bit = rx;

    uart_rx_ctrl #(.DATA_WIDTH(8), .PRESCALE(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .RX_IN       (rx),
        .PAR_EN      (par_en),
        .PAR_TYP     (par_typ),
        .sampled_bit (sampled_bit),
        .dat_samp_en (dat_samp_en),
        .edge_cnt    (edge_cnt),
        .P_DATA      (p_data),
        .data_valid  (data_valid),
        .par_err     (par_err),
        .stp_err     (stp_err)
`ifdef UART_RX_BREAK_DET_EN
        ,
        .brk_det     (brk)
`endif
    );

`ifndef UART_RX_BREAK_DET_EN
    assign brk = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (16) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                              input logic pbit, input logic sbit, input int idle_bits,
                              input logic [3:0] kind);
        exp_t e;
        par_en  = pe;
        par_typ = pt;
        e.kind  = kind;
        e.data  = (kind == K_DV) ? d : last_good;
        e.due   = cyc + 16 * (9 + int'(pe)) + 11;
        q.push_back(e);
        if (kind == K_DV) last_good = d;
        drive_bit(1'b0);
        par_en  = ~pe;
        par_typ = ~pt;
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (pe) drive_bit(pbit);
        drive_bit(sbit);
        for (int i = 0; i < idle_bits; i++) drive_bit(1'b1);
    endtask

    // Monitor: every output pulse must match the head of the scoreboard queue.
    logic [3:0] obs;
    exp_t       head;
    always @(negedge clk) begin
        if (rst && (data_valid || par_err || stp_err || brk)) begin
            obs = {brk, stp_err, par_err, data_valid};
            if (q.size() == 0) begin
                check("unexpected_pulse", {28'd0, obs}, 32'd0);
            end else begin
                head = q.pop_front();
                check("pulse_kind", {28'd0, obs}, {28'd0, head.kind});
                check("p_data", {24'd0, p_data}, {24'd0, head.data});
                check("latency", cyc, head.due);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        exp_t e;
        repeat (3) @(negedge clk);
        check("rst_edge_cnt", {28'd0, edge_cnt}, 32'd0);
        check("rst_samp_en", {31'd0, dat_samp_en}, 32'd0);
        check("rst_p_data", {24'd0, p_data}, 32'd0);
        check("rst_pulses", {28'd0, brk, stp_err, par_err, data_valid}, 32'd0);
        rst = 1'b1;
        repeat (20) @(negedge clk);

        // Plain frame, then even/odd parity good and bad
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 2, K_DV);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 2, K_DV);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b1, 1'b1, 2, K_PE);
        send_frame(8'h5A, 1'b1, 1'b1, 1'b1, 1'b1, 2, K_DV);
        send_frame(8'h5A, 1'b1, 1'b1, 1'b0, 1'b1, 2, K_PE);

        // Framing error then recovery
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 2, K_SE);
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 2, K_DV);

        // Start glitch
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (12) @(negedge clk);
        check("glitch_edge_cnt", {28'd0, edge_cnt}, 32'd0);
        check("glitch_samp_en", {31'd0, dat_samp_en}, 32'd0);
        repeat (20) @(negedge clk);

        // Back-to-back frames with no idle gap
        send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 0, K_DV);
        send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 2, K_DV);

        // Reset in the middle of the data bits
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        rx  = 1'b1;
        #1;
        check("midrst_edge_cnt", {28'd0, edge_cnt}, 32'd0);
        check("midrst_samp_en", {31'd0, dat_samp_en}, 32'd0);
        check("midrst_p_data", {24'd0, p_data}, 32'd0);
        check("midrst_pulses", {28'd0, brk, stp_err, par_err, data_valid}, 32'd0);
        last_good = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 2, K_DV);

        // Line held low for two frame times, then released
        par_en = 1'b0;
        c0 = cyc;
        e.data = last_good;
`ifdef UART_RX_BREAK_DET_EN
        e.kind = K_BRK;
        e.due  = c0 + 155;
        q.push_back(e);
`else
        e.kind = K_SE;
        e.due  = c0 + 155;
        q.push_back(e);
        e.due  = c0 + 310;
        q.push_back(e);
`endif
        rx = 1'b0;
        repeat (315) @(negedge clk);
        rx = 1'b1;
        repeat (48) @(negedge clk);
        check("release_samp_en", {31'd0, dat_samp_en}, 32'd0);
        check("release_edge_cnt", {28'd0, edge_cnt}, 32'd0);

        check("queue_drained", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
